// File: rtl/wide_add_sequencer.sv
// Streams multi-word add operands into an external adder stage, chaining carries between words.
// Define WIDE_ADD_OVF_EN to report signed overflow on the most-significant word.
module wide_add_sequencer #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_a,
    input  logic [width-1:0] in_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic [width-1:0] add_a,
    output logic [width-1:0] add_b,
    output logic             add_carry_in,
    output logic             add_carry_listen,
    output logic             add_on_off,
    input  logic [width-1:0] add_c,
    input  logic             add_carry_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_sum,
    output logic             out_last,
    output logic             out_carry,
    output logic             out_ovf
);

    typedef enum logic {IDLE, CHAIN} state_t;

    state_t           state;
    state_t           state_next;
    logic             op_valid;
    logic [width-1:0] op_a;
    logic [width-1:0] op_b;
    logic             op_first;
    logic             op_last;
    logic             carry;
    logic             advance;
    logic             accept;
    logic             eff_first;

    // A word arriving with no chain open always starts a new one.
    always_comb begin
        advance    = op_valid && (!out_valid || out_ready);
        in_ready   = !op_valid || advance;
        accept     = in_valid && in_ready;
        eff_first  = in_first || (state == IDLE);
        state_next = state;
        if (accept) begin
            if (in_last) begin
                state_next = IDLE;
            end else if (eff_first) begin
                state_next = CHAIN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_first <= 1'b0;
            op_last  <= 1'b0;
        end else if (accept) begin
            op_valid <= 1'b1;
            op_a     <= in_a;
            op_b     <= in_b;
            op_first <= eff_first;
            op_last  <= in_last;
        end else if (advance) begin
            op_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry <= 1'b0;
        end else if (advance) begin
            carry <= add_carry_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_carry <= 1'b0;
        end else if (advance) begin
            out_valid <= 1'b1;
            out_sum   <= add_c;
            out_last  <= op_last;
            out_carry <= op_last && add_carry_out;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef WIDE_ADD_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ovf <= 1'b0;
        end else if (advance) begin
            out_ovf <= op_last && (op_a[width-1] == op_b[width-1])
                               && (add_c[width-1] != op_a[width-1]);
        end
    end
`else
    assign out_ovf = 1'b0;
`endif

    assign add_a            = op_a;
    assign add_b            = op_b;
    assign add_on_off       = op_valid;
    assign add_carry_listen = op_valid && !op_first;
    assign add_carry_in     = carry;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer: behavioural adder stage, per-chain arithmetic model,
// directed corner cases followed by a randomized stream with random backpressure.
module tb_wide_add_sequencer;

    localparam int W = 16;
`ifdef WIDE_ADD_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         last;
        logic         carry;
        logic         ovf;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_carry_in;
    logic         add_carry_listen;
    logic         add_on_off;
    logic [W-1:0] add_c;
    logic         add_carry_out;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_last;
    logic         out_carry;
    logic         out_ovf;

    logic         rand_mode = 1'b0;
    logic         rand_ready = 1'b1;
    logic         ready_force = 1'b1;

    int           checks = 0;
    int           errors = 0;
    resp_t        sb[$];
    resp_t        seen[$];
    logic         chain_active = 1'b0;
    longint       chain_carry = 0;

    wide_add_sequencer #(.width(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_carry_in(add_carry_in),
        .add_carry_listen(add_carry_listen), .add_on_off(add_on_off),
        .add_c(add_c), .add_carry_out(add_carry_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_last(out_last), .out_carry(out_carry), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    // External adder stage: carry input only honoured when the sequencer asks for it.
    always_comb begin
        {add_carry_out, add_c} = {1'b0, add_a} + {1'b0, add_b}
                               + {{W{1'b0}}, add_carry_listen & add_carry_in};
    end

    always @(posedge clk) begin
        #1;
        rand_ready = ($urandom_range(0, 2) != 0);
    end

    assign out_ready = rand_mode ? rand_ready : ready_force;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks stalled outputs hold.
    resp_t held;
    logic  hold_pending = 1'b0;
    always @(negedge clk) begin
        resp_t act;
        resp_t exp;
        act = {out_sum, out_last, out_carry, out_ovf};
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checks++;
                if (act !== held || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_stable actual=%h valid=%b expected=%h valid=1",
                             act, out_valid, held);
                end
            end
            if (out_valid && out_ready) begin
                seen.push_back(act);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output actual sum=%h last=%b carry=%b ovf=%b expected none",
                             act.sum, act.last, act.carry, act.ovf);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL output actual sum=%h last=%b carry=%b ovf=%b expected sum=%h last=%b carry=%b ovf=%b",
                                 act.sum, act.last, act.carry, act.ovf,
                                 exp.sum, exp.last, exp.carry, exp.ovf);
                    end
                end
            end
            hold_pending = out_valid && !out_ready;
            held = act;
        end
    end

    // Offers one word, models its result when accepted, and checks it reached the adder port.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic first, input logic last);
        logic   eff_first;
        logic   got;
        longint s;
        longint ssum;
        resp_t  exp;
        in_a = a;
        in_b = b;
        in_first = first;
        in_last = last;
        in_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = in_ready;
        end
        if (!got) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        eff_first = first || !chain_active;
        if (eff_first) chain_carry = 0;
        s = longint'(a) + longint'(b) + chain_carry;
        ssum = longint'($signed(a)) + longint'($signed(b)) + chain_carry;
        chain_carry = s >> W;
        exp.sum = s[W-1:0];
        exp.last = last;
        exp.carry = last && (chain_carry != 0);
        exp.ovf = OVF_EN && last &&
                  (ssum > (longint'(1) << (W - 1)) - 1 || ssum < -(longint'(1) << (W - 1)));
        chain_active = !last;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("op_on_off", add_on_off, 1);
        check("op_carry_listen", add_carry_listen, !eff_first);
        check("op_operands", {add_a, add_b}, {a, b});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_seen(input int idx, input logic [W-1:0] sum,
                              input logic last, input logic carry, input logic ovf);
        if (idx >= seen.size()) begin
            check("seen_count", seen.size(), idx + 1);
        end else begin
            check("seen_result", seen[idx], {sum, last, carry, ovf});
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", in_ready, 1);
        check("rst_on_off", add_on_off, 0);
        check("rst_carry_listen", add_carry_listen, 0);
        check("rst_carry_in", add_carry_in, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_flags", {out_last, out_carry, out_ovf}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_out_valid", out_valid, 0);

        // Single word signed overflow, two-edge latency.
        seen.delete();
        send(16'h7FFF, 16'h0001, 1'b1, 1'b1);
        check("lat_edge1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_edge2_valid", out_valid, 1);
        drain();
        check_seen(0, 16'h8000, 1'b1, 1'b0, OVF_EN);

        // Three-word chain with ripple into the top word.
        seen.delete();
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b0, 1'b0);
        send(16'h0001, 16'h0000, 1'b0, 1'b1);
        drain();
        check_seen(0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_seen(1, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_seen(2, 16'h0002, 1'b1, 1'b0, 1'b0);

        // Carry out of the most-significant word.
        seen.delete();
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b0, 1'b1);
        drain();
        check_seen(0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_seen(1, 16'h0000, 1'b1, 1'b1, 1'b0);

        // Backpressure across a 4-word stream.
        seen.delete();
        ready_force = 1'b0;
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b0, 1'b0);
        check("bp_in_ready", in_ready, 0);
        fork
            begin
                send(16'h1234, 16'h0000, 1'b0, 1'b0);
                send(16'hFFFF, 16'h0000, 1'b0, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1 ready_force = 1'b1;
            end
        join
        drain();
        check("bp_seen_count", seen.size(), 4);
        check_seen(0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_seen(1, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_seen(2, 16'h1235, 1'b0, 1'b0, 1'b0);
        check_seen(3, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Reset mid-chain; the next word opens a fresh chain.
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs();
        sb.delete();
        chain_active = 1'b0;
        chain_carry = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        seen.delete();
        send(16'h0005, 16'h0003, 1'b0, 1'b1);
        drain();
        check_seen(0, 16'h0008, 1'b1, 1'b0, 1'b0);

        // in_first inside an open chain restarts it.
        seen.delete();
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        send(16'h0010, 16'h0020, 1'b1, 1'b0);
        send(16'h0001, 16'h0001, 1'b0, 1'b1);
        drain();
        check_seen(1, 16'h0030, 1'b0, 1'b0, 1'b0);
        check_seen(2, 16'h0002, 1'b1, 1'b0, 1'b0);

        // Randomized stream with random backpressure and gaps.
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: a = 16'hFFFF;
                1: a = 16'h7FFF;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: b = 16'h0001;
                1: b = 16'h8000;
                default: b = W'($urandom);
            endcase
            send(a, b, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_mode = 1'b0;
        ready_force = 1'b1;
        drain();
        check("final_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
